// File: rtl/heartbeat_monitor_if.sv
// heartbeat_monitor_if: heartbeat input and monitor status bundle
// master: drives i_heartbeat and observes status (board side / bench)
// slave : heartbeat_monitor itself
// CW    : measurement width, must match the monitor's CW
interface heartbeat_monitor_if #(
    parameter int CW = 24
);
    logic          i_heartbeat;
    logic          o_alive;
    logic          o_lost;
    logic          o_fault;
    logic          o_period_valid;
    logic [CW-1:0] o_period;
    logic [CW-1:0] o_high_time;
    logic [15:0]   o_err_count;
    modport master (
        output i_heartbeat,
        input  o_alive, o_lost, o_fault, o_period_valid, o_period, o_high_time, o_err_count
    );
    modport slave (
        input  i_heartbeat,
        output o_alive, o_lost, o_fault, o_period_valid, o_period, o_high_time, o_err_count
    );
endinterface

// File: rtl/heartbeat_monitor.sv
// heartbeat_monitor: measures heartbeat period/high time and tracks alive, fault and lost status
// Ports: clk, reset (async, active-high), hb (heartbeat_monitor_if.slave):
//   i_heartbeat in; o_alive, o_lost, o_fault, o_period_valid, o_period, o_high_time, o_err_count out
// Optional: HEARTBEAT_MON_STATS_EN enables the saturating bad-period/timeout counter on o_err_count
module heartbeat_monitor #(
    parameter int Modulo    = 12_000_000,
    parameter int Duty      = 2_400_000,
    parameter int Tolerance = 120_000,
    parameter int LockCount = 3,
    parameter int CW        = $clog2(Modulo + Tolerance + 2)
) (
    input logic                clk,
    input logic                reset,
    heartbeat_monitor_if.slave hb
);
    localparam int GW = $clog2(LockCount + 1);
    localparam logic [CW-1:0] PMAX = CW'(Modulo + Tolerance);
    localparam logic [CW-1:0] P_LO = CW'(Modulo > Tolerance ? Modulo - Tolerance : 0);
    localparam logic [CW-1:0] P_HI = CW'(Modulo + Tolerance);
    localparam logic [CW-1:0] H_LO = CW'(Duty > Tolerance ? Duty - Tolerance : 0);
    localparam logic [CW-1:0] H_HI = CW'(Duty + Tolerance);
    typedef enum logic [1:0] {LOST, ACQUIRE, LOCKED} state_t;
    state_t        state;
    logic          s1, s2, s3, fell;
    logic [CW-1:0] per_cnt, hi_cnt, meas_p, meas_h;
    logic [GW-1:0] good_cnt;
    logic          rise_evt, fall_evt, timeout, good;
    assign rise_evt = s2 & ~s3;
    assign fall_evt = ~s2 & s3;
    // both counts include the rise cycle itself, so a pulse of N sampled cycles measures N
    assign meas_p   = per_cnt + 1'b1;
    assign meas_h   = fell ? hi_cnt + 1'b1 : meas_p;
    assign good     = meas_p >= P_LO && meas_p <= P_HI && meas_h >= H_LO && meas_h <= H_HI;
    // a rise on the saturation cycle is a (bad) period, not a timeout
    assign timeout  = per_cnt == PMAX && !rise_evt && state != LOST;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {s1, s2, s3, fell}   <= '0;
            per_cnt              <= '0;
            hi_cnt               <= '0;
            good_cnt             <= '0;
            state                <= LOST;
            hb.o_alive           <= 1'b0;
            hb.o_lost            <= 1'b0;
            hb.o_fault           <= 1'b0;
            hb.o_period_valid    <= 1'b0;
            hb.o_period          <= '0;
            hb.o_high_time       <= '0;
        end else begin
            s1                <= hb.i_heartbeat;
            s2                <= s1;
            s3                <= s2;
            per_cnt           <= rise_evt ? '0 : (per_cnt == PMAX ? per_cnt : per_cnt + 1'b1);
            // high time freezes at the first fall so later glitches cannot extend it
            hi_cnt            <= rise_evt ? '0 : (s2 && !fell && hi_cnt != PMAX ? hi_cnt + 1'b1 : hi_cnt);
            fell              <= rise_evt ? 1'b0 : fell | fall_evt;
            hb.o_lost         <= 1'b0;
            hb.o_fault        <= 1'b0;
            hb.o_period_valid <= 1'b0;
            if (timeout) begin
                state      <= LOST;
                good_cnt   <= '0;
                hb.o_alive <= 1'b0;
                hb.o_lost  <= 1'b1;
            end else if (rise_evt) begin
                if (state == LOST) begin
                    state    <= ACQUIRE;
                    good_cnt <= '0;
                end else begin
                    hb.o_period       <= meas_p;
                    hb.o_high_time    <= meas_h;
                    hb.o_period_valid <= 1'b1;
                    if (!good) begin
                        hb.o_fault <= state == LOCKED;
                        hb.o_alive <= 1'b0;
                        state      <= ACQUIRE;
                        good_cnt   <= '0;
                    end else if (state == ACQUIRE && 32'(good_cnt) + 1 >= LockCount) begin
                        state      <= LOCKED;
                        hb.o_alive <= 1'b1;
                    end else if (state == ACQUIRE) begin
                        good_cnt <= good_cnt + 1'b1;
                    end
                end
            end
        end
    end
`ifdef HEARTBEAT_MON_STATS_EN
    logic [15:0] err_cnt;
    logic        err_evt;
    assign err_evt = timeout || (rise_evt && state != LOST && !good);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_cnt <= '0;
        else if (err_evt && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 1'b1;
    end
    assign hb.o_err_count = err_cnt;
`else
    assign hb.o_err_count = 16'h0000;
`endif
endmodule
